// File: rtl/layer_timestep_sched_pkg.sv
// Shared types and defaults for the layer timestep scheduler.
package layer_timestep_sched_pkg;

  localparam int SCHED_SETTLE_DEFAULT = 3;
  localparam int SCHED_CLR_DEFAULT    = 2;
  localparam int SCHED_CNT_W          = 8;

  typedef logic [SCHED_CNT_W-1:0] spike_cnt_t;

  typedef enum logic [2:0] {
    SCHED_IDLE    = 3'd0,
    SCHED_CLEAR   = 3'd1,
    SCHED_WAIT_IN = 3'd2,
    SCHED_STIM    = 3'd3,
    SCHED_SETTLE  = 3'd4,
    SCHED_UPDATE  = 3'd5,
    SCHED_DONE    = 3'd6
  } sched_state_e;

endpackage

// File: rtl/layer_timestep_sched_if.sv
// Input-frame and count-readout handshakes of the timestep scheduler.
interface layer_timestep_sched_if #(
  parameter int INPUT_COUNT  = 16,
  parameter int NEURON_COUNT = 8,
  parameter int CNT_W        = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_spikes [INPUT_COUNT];
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] spike_count [NEURON_COUNT];

  modport master (
    output in_valid, in_spikes, out_ready,
    input  in_ready, out_valid, spike_count
  );

  modport slave (
    input  in_valid, in_spikes, out_ready,
    output in_ready, out_valid, spike_count
  );
endinterface

// File: rtl/layer_timestep_sched_counter_bank.sv
// Per-neuron saturating spike counters, cleared at window start.
module spike_counter_bank #(
  parameter int NEURON_COUNT = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             hit   [NEURON_COUNT],
  output logic [CNT_W-1:0] count [NEURON_COUNT]
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q [NEURON_COUNT];
  logic [CNT_W-1:0] count_d [NEURON_COUNT];

  for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_cnt
    always_comb begin
      count_d[gi] = count_q[gi];
      if (clr) begin
        count_d[gi] = '0;
      end else if (inc_en && hit[gi] && (count_q[gi] != CNT_MAX)) begin
        count_d[gi] = count_q[gi] + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q[gi] <= '0;
      end else begin
        count_q[gi] <= count_d[gi];
      end
    end

    assign count[gi] = count_q[gi];
  end
endmodule

// File: rtl/layer_timestep_sched.sv
// Presents spike frames to a neuron layer one timestep at a time and
// accumulates per-neuron output spike counts over a programmable window.
module layer_timestep_sched
  import layer_timestep_sched_pkg::*;
#(
  parameter int INPUT_COUNT   = 16,
  parameter int NEURON_COUNT  = 8,
  parameter int SETTLE_CYCLES = SCHED_SETTLE_DEFAULT,
  parameter int CLR_CYCLES    = SCHED_CLR_DEFAULT,
  parameter int STEP_W        = 8,
  parameter int CNT_W         = SCHED_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  output logic              busy,
  layer_timestep_sched_if.slave io,
  output logic              layer_spikes_o [INPUT_COUNT],
  input  logic              layer_spikes_i [NEURON_COUNT],
  output logic              layer_rst_n
);
  localparam logic [2:0] ST_IDLE    = 3'(SCHED_IDLE);
  localparam logic [2:0] ST_CLEAR   = 3'(SCHED_CLEAR);
  localparam logic [2:0] ST_WAIT_IN = 3'(SCHED_WAIT_IN);
  localparam logic [2:0] ST_STIM    = 3'(SCHED_STIM);
  localparam logic [2:0] ST_SETTLE  = 3'(SCHED_SETTLE);
  localparam logic [2:0] ST_UPDATE  = 3'(SCHED_UPDATE);
  localparam logic [2:0] ST_DONE    = 3'(SCHED_DONE);

  localparam int         PH_W        = 8;
  localparam logic [PH_W-1:0] CLR_LAST    = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] step_inc;
  logic              frame_q [INPUT_COUNT];
  logic              frame_d [INPUT_COUNT];
  logic              stim_q  [INPUT_COUNT];
  logic              stim_d  [INPUT_COUNT];
  logic              hit_q   [NEURON_COUNT];
  logic              hit_d   [NEURON_COUNT];
  logic [CNT_W-1:0]  count_w [NEURON_COUNT];

  assign step_inc = step_cnt_q + STEP_W'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    frame_d    = frame_q;
    hit_d      = hit_q;
    for (int i = 0; i < INPUT_COUNT; i++) stim_d[i] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          steps_d = num_steps;
          phase_d = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        step_cnt_d = '0;
        for (int n = 0; n < NEURON_COUNT; n++) hit_d[n] = 1'b0;
        phase_d = phase_q + PH_W'(1);
        if (phase_q == CLR_LAST) begin
          phase_d = '0;
          state_d = (steps_q == '0) ? ST_DONE : ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (io.in_valid) begin
          frame_d = io.in_spikes;
          state_d = ST_STIM;
        end
      end
      ST_STIM: begin
        phase_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Repeated firing within one settle window collapses into a single hit.
        for (int n = 0; n < NEURON_COUNT; n++) hit_d[n] = hit_q[n] | layer_spikes_i[n];
        phase_d = phase_q + PH_W'(1);
        if (phase_q == SETTLE_LAST) begin
          phase_d = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int n = 0; n < NEURON_COUNT; n++) hit_d[n] = 1'b0;
        step_cnt_d = step_inc;
        state_d    = (step_inc == steps_q) ? ST_DONE : ST_WAIT_IN;
      end
      ST_DONE: begin
        if (io.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered stimulus: the frame is on the layer input only during STIM.
    if (state_d == ST_STIM) stim_d = frame_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      for (int i = 0; i < INPUT_COUNT; i++) begin
        frame_q[i] <= 1'b0;
        stim_q[i]  <= 1'b0;
      end
      for (int n = 0; n < NEURON_COUNT; n++) hit_q[n] <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      frame_q    <= frame_d;
      stim_q     <= stim_d;
      hit_q      <= hit_d;
    end
  end

  spike_counter_bank #(
    .NEURON_COUNT (NEURON_COUNT),
    .CNT_W        (CNT_W)
  ) u_counters (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_CLEAR),
    .inc_en (state_q == ST_UPDATE),
    .hit    (hit_q),
    .count  (count_w)
  );

  assign io.spike_count = count_w;
  assign io.in_ready    = (state_q == ST_WAIT_IN);
  assign io.out_valid   = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign layer_rst_n    = !rst && (state_q != ST_CLEAR);
  assign layer_spikes_o = stim_q;
endmodule

// File: tb/tb_layer_timestep_sched.sv
// Directed self-checking bench for layer_timestep_sched with a small layer model.
module tb_layer_timestep_sched;
  localparam int IC = 16;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_steps = 8'd0;
  logic       busy;
  logic       layer_spikes_o [IC];
  logic       layer_spikes_i [NC];
  logic       layer_rst_n;

  int tests_run = 0;
  int tests_failed = 0;
  int stim_pulses = 0;

  logic fire3_en = 1'b0;
  logic junk_en = 1'b0;
  logic stim_any;
  logic d1_any = 1'b0, d2_any = 1'b0, d3_any = 1'b0;
  logic d1_b0 = 1'b0, d2_b0 = 1'b0;

  layer_timestep_sched_if #(.INPUT_COUNT(IC), .NEURON_COUNT(NC), .CNT_W(4)) bus ();

  layer_timestep_sched #(
    .INPUT_COUNT(IC), .NEURON_COUNT(NC), .SETTLE_CYCLES(3),
    .CLR_CYCLES(2), .STEP_W(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .busy(busy),
    .io(bus), .layer_spikes_o(layer_spikes_o), .layer_spikes_i(layer_spikes_i),
    .layer_rst_n(layer_rst_n)
  );

  always #5 clk = ~clk;

  // Layer model: neuron 0 echoes input 0 two cycles after the stimulus,
  // neuron 3 fires on both of the first two settle cycles, neuron 5 fires
  // only outside the settle window.
  always_comb begin
    stim_any = 1'b0;
    for (int i = 0; i < IC; i++) stim_any = stim_any | layer_spikes_o[i];
  end

  always @(posedge clk) begin
    d1_any <= stim_any;
    d2_any <= d1_any;
    d3_any <= d2_any;
    d1_b0  <= layer_spikes_o[0];
    d2_b0  <= d1_b0;
    if (stim_any) stim_pulses <= stim_pulses + 1;
  end

  always_comb begin
    for (int n = 0; n < NC; n++) layer_spikes_i[n] = 1'b0;
    layer_spikes_i[0] = d2_b0;
    layer_spikes_i[3] = fire3_en & (d1_any | d2_any);
    layer_spikes_i[5] = junk_en & ~(d1_any | d2_any | d3_any);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [15:0] f);
    for (int i = 0; i < IC; i++) bus.in_spikes[i] = f[i];
  endtask

  task automatic begin_window(input logic [7:0] n);
    num_steps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_in_ready(inout int k, input int limit);
    while (bus.in_ready !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_out_valid(inout int k, input int limit);
    while (bus.out_valid !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_frame(16'h0000);
    rst = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if ({busy, bus.in_ready, bus.out_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/in_ready/out_valid=%b required 000", {busy, bus.in_ready, bus.out_valid});
    end
    tests_run++;
    if (layer_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_layer_rst_n: got %b required 0", layer_rst_n);
    end
    bad = 0;
    for (int n = 0; n < NC; n++) if (bus.spike_count[n] !== 4'd0) bad++;
    for (int i = 0; i < IC; i++) if (layer_spikes_o[i] !== 1'b0) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_outputs_zero: %0d nonzero bits/counts, required 0", bad);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (layer_rst_n !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: layer_rst_n=%b busy=%b required 1 0", layer_rst_n, busy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_step();
    int k;
    int bad;
    fire3_en = 1'b0;
    junk_en = 1'b1;
    set_frame(16'h0081);
    bus.in_valid = 1'b1;
    begin_window(8'd1);
    k = 1;
    wait_in_ready(k, 20);
    tests_run++;
    if (k != 3) begin
      tests_failed++;
      $display("FAIL start_latency: in_ready after %0d cycles, required 3", k);
    end
    wait_out_valid(k, 40);
    tests_run++;
    if (k + 1 != 10) begin
      tests_failed++;
      $display("FAIL window_len_single: %0d cycles, required 10", k + 1);
    end
    tests_run++;
    if (bus.spike_count[0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL single_count0: got %0d required 1", bus.spike_count[0]);
    end
    bad = 0;
    for (int n = 1; n < NC; n++) if (bus.spike_count[n] !== 4'd0) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL single_others_zero: %0d nonzero counts, required 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b required 0", busy);
    end
    $display("[TB] test_single_step done");
  endtask

  task automatic test_full_window();
    int k;
    fire3_en = 1'b1;
    set_frame(16'h0201);
    bus.in_valid = 1'b1;
    stim_pulses = 0;
    begin_window(8'd4);
    k = 1;
    wait_out_valid(k, 100);
    tests_run++;
    if (k + 1 != 28) begin
      tests_failed++;
      $display("FAIL window_len_full: %0d cycles, required 28", k + 1);
    end
    tests_run++;
    if (bus.spike_count[3] !== 4'd4 || bus.spike_count[0] !== 4'd4) begin
      tests_failed++;
      $display("FAIL full_counts: n3=%0d n0=%0d required 4 4", bus.spike_count[3], bus.spike_count[0]);
    end
    tests_run++;
    if (bus.spike_count[5] !== 4'd0) begin
      tests_failed++;
      $display("FAIL outside_settle_ignored: n5=%0d required 0", bus.spike_count[5]);
    end
    tests_run++;
    if (stim_pulses != 4) begin
      tests_failed++;
      $display("FAIL stim_pulses: got %0d required 4", stim_pulses);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    $display("[TB] test_full_window done");
  endtask

  task automatic test_backpressure();
    int k;
    fire3_en = 1'b0;
    set_frame(16'h0001);
    bus.in_valid = 1'b0;
    stim_pulses = 0;
    begin_window(8'd3);
    k = 1;
    for (int s = 0; s < 3; s++) begin
      wait_in_ready(k, 200);
      if (s == 1) begin
        for (int j = 0; j < 5; j++) tick();
        k += 5;
        tests_run++;
        if (bus.in_ready !== 1'b1 || stim_pulses != 1) begin
          tests_failed++;
          $display("FAIL bp_stall: in_ready=%b pulses=%0d required 1 1", bus.in_ready, stim_pulses);
        end
      end
      bus.in_valid = 1'b1;
      tick();
      k++;
      bus.in_valid = 1'b0;
    end
    wait_out_valid(k, 200);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.spike_count[0] !== 4'd3 || stim_pulses != 3) begin
      tests_failed++;
      $display("FAIL bp_done: out_valid=%b n0=%0d pulses=%0d required 1 3 3",
               bus.out_valid, bus.spike_count[0], stim_pulses);
    end
    bus.in_valid = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.spike_count[0] !== 4'd3) begin
      tests_failed++;
      $display("FAIL bp_done_stable: out_valid=%b n0=%0d required 1 3", bus.out_valid, bus.spike_count[0]);
    end
    bus.out_ready = 1'b1;
    start = 1'b1;
    num_steps = 8'd5;
    tick();
    bus.out_ready = 1'b0;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_handshake_idle: busy=%b out_valid=%b required 0 0", busy, bus.out_valid);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_on_handshake: busy=%b required 0", busy);
    end
    bus.in_valid = 1'b0;
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_saturation();
    int k;
    fire3_en = 1'b1;
    set_frame(16'h0001);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    begin_window(8'd20);
    k = 1;
    wait_out_valid(k, 300);
    tests_run++;
    if (k + 1 != 124) begin
      tests_failed++;
      $display("FAIL window_len_sat: %0d cycles, required 124", k + 1);
    end
    tests_run++;
    if (bus.spike_count[0] !== 4'd15 || bus.spike_count[3] !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturation: n0=%0d n3=%0d required 15 15", bus.spike_count[0], bus.spike_count[3]);
    end
    tick();
    bus.out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_idle: busy=%b required 0", busy);
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_zero_steps();
    int k;
    int bad;
    logic seen_ready;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    seen_ready = 1'b0;
    begin_window(8'd0);
    k = 1;
    tests_run++;
    if (layer_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_layer_rst_n: got %b required 0", layer_rst_n);
    end
    num_steps = 8'd5;
    start = 1'b1;
    tick();
    k++;
    start = 1'b0;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      if (bus.in_ready === 1'b1) seen_ready = 1'b1;
      tick();
      k++;
    end
    tests_run++;
    if (k != 3 || seen_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_steps: done after %0d cycles in_ready_seen=%b required 3 0", k, seen_ready);
    end
    bad = 0;
    for (int n = 0; n < NC; n++) if (bus.spike_count[n] !== 4'd0) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL zero_counts: %0d nonzero counts, required 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_ignores_start: out_valid=%b in_ready=%b required 1 0", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    $display("[TB] test_zero_steps done");
  endtask

  task automatic test_mid_reset();
    int k;
    int bad;
    fire3_en = 1'b1;
    set_frame(16'h0001);
    bus.in_valid = 1'b1;
    stim_pulses = 0;
    begin_window(8'd4);
    k = 1;
    while (stim_pulses < 2 && k < 100) begin
      tick();
      k++;
    end
    tests_run++;
    if (stim_pulses != 2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reach_step2: pulses=%0d busy=%b required 2 1", stim_pulses, busy);
    end
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (layer_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_layer_rst_n: got %b required 0", layer_rst_n);
    end
    tick();
    bad = 0;
    for (int n = 0; n < NC; n++) if (bus.spike_count[n] !== 4'd0) bad++;
    for (int i = 0; i < IC; i++) if (layer_spikes_o[i] !== 1'b0) bad++;
    tests_run++;
    if (bad != 0 || busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: nonzero=%0d busy=%b in_ready=%b out_valid=%b required 0 0 0 0",
               bad, busy, bus.in_ready, bus.out_valid);
    end
    rst = 1'b0;
    tick();
    begin_window(8'd2);
    k = 1;
    wait_out_valid(k, 100);
    tests_run++;
    if (k + 1 != 16 || bus.spike_count[0] !== 4'd2 || bus.spike_count[3] !== 4'd2) begin
      tests_failed++;
      $display("FAIL clean_after_reset: len=%0d n0=%0d n3=%0d required 16 2 2",
               k + 1, bus.spike_count[0], bus.spike_count[3]);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    $display("[TB] test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_full_window();
    test_backpressure();
    test_saturation();
    test_zero_steps();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
